// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared constants, types and pc helpers for the fetch unit
package inst_fetch_unit_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;
  localparam int          OPCODE_W         = 6;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  // Sequential fetch step; natural 32-bit wrap takes FFFF_FFFC to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with full/empty/count and synchronous clear
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is dropped unless a pop frees a slot on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Data storage: no reset needed, entries are only observed once written.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - credit-limited instruction fetcher with redirect flush and decode buffer
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                o_imem_req,
  output logic [31:0]         o_imem_addr,
  input  logic                i_imem_gnt,
  input  logic                i_imem_rvalid,
  input  logic [INSTR_W-1:0]  i_imem_rdata,
  input  logic                i_redirect,
  input  logic [31:0]         i_redirect_pc,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [INSTR_W-1:0]  o_out_instr,
  output logic [31:0]         o_out_pc,
  output logic [OPCODE_W-1:0] o_out_opcode
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BUF_W = INSTR_W + 32;

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      w_fetch_pc_nxt;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    w_outstanding_nxt;
  logic [CW-1:0]    r_drop_cnt;
  logic [CW-1:0]    w_drop_cnt_nxt;

  logic             w_req;
  logic             w_credit;
  logic             w_accept;
  logic             w_resp_any;
  logic             w_resp_keep;
  logic             w_pop;

  logic [BUF_W-1:0] w_buf_rdata;
  logic             w_buf_full;
  logic             w_buf_empty;
  logic [CW-1:0]    w_buf_count;
  logic [31:0]      w_aq_pc;
  logic             w_aq_full;
  logic             w_aq_empty;
  logic [CW-1:0]    w_aq_count;
  logic             w_unused;

  // Requests in flight plus buffered instructions may never exceed the buffer size,
  // which guarantees every kept response has a free slot.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < (CW + 1)'(DEPTH);
  // A response with nothing outstanding cannot belong to us and is ignored.
  assign w_resp_any = i_imem_rvalid && (r_outstanding != '0);
  assign o_imem_req = rst_n && w_req;
  assign w_accept   = o_imem_req && i_imem_gnt;
  assign o_imem_addr = r_fetch_pc;
  assign w_pop      = o_out_valid && i_out_ready;

  // Next state, drop counter and request/keep decisions; redirect overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_drop_cnt_nxt = r_drop_cnt;
    w_req          = 1'b0;
    w_resp_keep    = 1'b0;
    if (i_redirect) begin
      w_drop_cnt_nxt = r_outstanding - CW'(w_resp_any);
      w_state_nxt    = (w_drop_cnt_nxt != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_req       = w_credit;
          w_resp_keep = w_resp_any;
        end
        ST_FLUSH: begin
          if (w_resp_any && (r_drop_cnt != '0)) begin
            w_drop_cnt_nxt = r_drop_cnt - CW'(1);
          end
          if (w_drop_cnt_nxt == '0) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Outstanding count and fetch address next values.
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_accept && !w_resp_any) begin
      w_outstanding_nxt = r_outstanding + CW'(1);
    end else if (!w_accept && w_resp_any) begin
      w_outstanding_nxt = r_outstanding - CW'(1);
    end
    w_fetch_pc_nxt = r_fetch_pc;
    if (i_redirect) begin
      w_fetch_pc_nxt = pc_align(i_redirect_pc);
    end else if (w_accept) begin
      w_fetch_pc_nxt = pc_inc(r_fetch_pc);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_fetch_pc    <= PC_RESET;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
    end
  end

  // Address queue: remembers the pc of each accepted request until its response returns.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_addr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_redirect),
    .i_push  (w_accept),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_resp_keep),
    .o_rdata (w_aq_pc),
    .o_full  (w_aq_full),
    .o_empty (w_aq_empty),
    .o_count (w_aq_count)
  );

  // Instruction buffer: {instruction, pc} pairs presented to decode.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BUF_W)
  ) u_instr_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_redirect),
    .i_push  (w_resp_keep),
    .i_wdata ({i_imem_rdata, w_aq_pc}),
    .i_pop   (w_pop),
    .o_rdata (w_buf_rdata),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_count (w_buf_count)
  );

  assign o_out_valid  = !w_buf_empty;
  assign o_out_instr  = o_out_valid ? w_buf_rdata[BUF_W-1:32] : '0;
  assign o_out_pc     = o_out_valid ? w_buf_rdata[31:0] : '0;
  assign o_out_opcode = o_out_instr[INSTR_W-1 -: OPCODE_W];

  assign w_unused = ^{i_redirect_pc[1:0], w_aq_full, w_aq_empty, w_aq_count, w_buf_full};

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_out_ready = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_out_valid;
  logic [31:0] o_out_instr;
  logic [31:0] o_out_pc;
  logic [5:0]  o_out_opcode;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .PC_RESET (PC_RST),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_instr   (o_out_instr),
    .o_out_pc      (o_out_pc),
    .o_out_opcode  (o_out_opcode)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  // memory environment: accepted requests waiting to be answered, in order
  typedef struct { logic [31:0] pc; int due; } mem_t;
  mem_t mem_q[$];

  // reference model: requests in flight (stale once a redirect overtakes them) and buffer
  typedef struct { logic [31:0] pc; bit stale; } inf_t;
  inf_t        m_inf[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_pc;

  // outputs sampled during the most recent step
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;
  logic [5:0]  s_opc;

  typedef struct {
    bit rst_before; bit gnt; bit ready;
    bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
  } vec_t;
  vec_t tv[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] opc_of(input logic [31:0] a);
    logic [31:0] w;
    w = word(a);
    return {26'd0, w[31:26]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic row(input bit rb, input bit g, input bit r, input bit q,
                     input logic [31:0] a, input bit v, input logic [31:0] p);
    vec_t t;
    t.rst_before = rb; t.gnt = g; t.ready = r;
    t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
    tv.push_back(t);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model and memory.
  task automatic step(input bit gnt, input bit ready, input bit redir,
                      input logic [31:0] rpc, input bit rsp_ok);
    bit   resp, any_stale, exp_req, kept;
    inf_t r, n;
    logic [31:0] rsp_pc;
    @(negedge clk);
    i_imem_gnt    = gnt;
    i_out_ready   = ready;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    resp          = rsp_ok && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rsp_pc        = resp ? mem_q[0].pc : 32'h0;
    i_imem_rvalid = resp;
    i_imem_rdata  = resp ? word(rsp_pc) : $urandom;
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_out_valid;
    s_pc = o_out_pc; s_opc = o_out_opcode;

    any_stale = 1'b0;
    foreach (m_inf[k]) if (m_inf[k].stale) any_stale = 1'b1;
    exp_req = !any_stale && !redir && ((m_inf.size() + m_fifo.size()) < DEPTH);
    chk("imem_req", 32'(o_imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", o_imem_addr, m_pc);
    chk("out_valid", 32'(o_out_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      chk("out_pc", o_out_pc, m_fifo[0]);
      chk("out_instr", o_out_instr, word(m_fifo[0]));
      chk("out_opcode", 32'(o_out_opcode), opc_of(m_fifo[0]));
    end

    // environment reacts to what the DUT actually did
    if (resp) mem_q.delete(0);
    if (o_imem_req && gnt) begin
      mem_t m;
      m.pc = o_imem_addr; m.due = cyc + lat;
      mem_q.push_back(m);
    end

    // model update
    kept = 1'b0;
    if (resp && (m_inf.size() > 0)) begin
      r = m_inf[0];
      m_inf.delete(0);
      kept = !r.stale;
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_inf[k]) m_inf[k].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (ready && (m_fifo.size() > 0)) m_fifo.delete(0);
      if (kept) m_fifo.push_back(r.pc);
      if (exp_req && gnt) begin
        n.pc = m_pc; n.stale = 1'b0;
        m_inf.push_back(n);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", 32'(o_imem_req), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_instr", o_out_instr, 32'd0);
    chk("rst_out_pc", o_out_pc, 32'd0);
    chk("rst_out_opcode", 32'(o_out_opcode), 32'd0);
    chk("rst_imem_addr", o_imem_addr, PC_RST);
    mem_q.delete(); m_inf.delete(); m_fifo.delete();
    m_pc = PC_RST;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_redirect = 1'b0; i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_after_release", 32'(o_imem_req), 32'd1);
  endtask

  task automatic wait_first_pc(input string name, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      if (s_valid) got = 1'b1;
    end
    chk(name, got ? s_pc : 32'hDEAD_BEEF, exp);
  endtask

  initial begin
    logic [31:0] a0;

    // zero-wait memory, decode always ready: one instruction per cycle
    row(1, 1, 1, 1, 32'd0,  0, 32'd0);
    row(0, 1, 1, 1, 32'd4,  0, 32'd0);
    row(0, 1, 1, 1, 32'd8,  1, 32'd0);
    row(0, 1, 1, 1, 32'd12, 1, 32'd4);
    row(0, 1, 1, 1, 32'd16, 1, 32'd8);
    row(0, 1, 1, 1, 32'd20, 1, 32'd12);
    // decode stalled: exactly DEPTH requests, then drain in order and resume
    row(1, 1, 0, 1, 32'd0,  0, 32'd0);
    row(0, 1, 0, 1, 32'd4,  0, 32'd0);
    row(0, 1, 0, 1, 32'd8,  1, 32'd0);
    row(0, 1, 0, 1, 32'd12, 1, 32'd0);
    row(0, 1, 0, 0, 32'd0,  1, 32'd0);
    row(0, 1, 0, 0, 32'd0,  1, 32'd0);
    row(0, 1, 1, 0, 32'd0,  1, 32'd0);
    row(0, 1, 1, 1, 32'd16, 1, 32'd4);
    row(0, 1, 1, 1, 32'd20, 1, 32'd8);
    row(0, 1, 1, 1, 32'd24, 1, 32'd12);
    row(0, 1, 1, 1, 32'd28, 1, 32'd16);
    row(0, 1, 1, 1, 32'd32, 1, 32'd20);

    lat = 1;
    foreach (tv[i]) begin
      if (tv[i].rst_before) do_reset();
      step(tv[i].gnt, tv[i].ready, 1'b0, 32'h0, 1'b1);
      chk("tv_req", 32'(s_req), 32'(tv[i].exp_req));
      if (tv[i].exp_req) chk("tv_addr", s_addr, tv[i].exp_addr);
      chk("tv_valid", 32'(s_valid), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) begin
        chk("tv_pc", s_pc, tv[i].exp_pc);
        chk("tv_opcode", 32'(s_opc), opc_of(tv[i].exp_pc));
      end
    end

    // grant withheld for three cycles: address must hold steady
    do_reset();
    lat = 1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    a0 = s_addr;
    repeat (2) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("gnt_low_addr_stable", s_addr, a0);
    end
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // latency 3, redirect with two requests in flight
    do_reset();
    lat = 3;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
    repeat (2) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("flush_req_low", 32'(s_req), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("post_flush_req", 32'(s_req), 32'd1);
    chk("post_flush_addr", s_addr, 32'h0000_0100);
    wait_first_pc("first_pc_after_flush", 32'h0000_0100);

    // redirect coinciding with a response and a pop, then a wrapping redirect
    do_reset();
    lat = 1;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_rvalid_empty", 32'(s_valid), 32'd0);
    chk("redir_rvalid_req", 32'(s_req), 32'd1);
    chk("redir_rvalid_addr", s_addr, 32'h0000_0200);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b1);
    wait_first_pc("first_pc_wrap", 32'hFFFF_FFF8);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // reset with three requests outstanding
    lat = 3;
    do_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    do_reset();
    wait_first_pc("first_pc_after_reset", PC_RST);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      lat = $urandom_range(1, 4);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 23) == 0,
           $urandom, ($urandom % 5) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4 (power of two, 2..16), sets the instruction buffer entries and the outstanding-request limit.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request valid.
REQ-006 imem_addr  out  32  word-aligned fetch address.
REQ-007 imem_gnt  in  1  request accepted when imem_req&&imem_gnt.
REQ-008 imem_rvalid  in  1  response valid; responses in request order, at most one per cycle, latency >=1 cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect  in  1  branch/jump taken; has priority over all other events.
REQ-011 redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced 0).
REQ-012 out_valid  out  1  buffered instruction available to the CPU decode stage.
REQ-013 out_ready  in  1  decode consumes when out_valid&&out_ready.
REQ-014 out_instr  out  32  head instruction.
REQ-015 out_pc  out  32  address of out_instr.
REQ-016 out_opcode  out  6  out_instr[31:26].

Function
REQ-017 States: RUN, FLUSH; reset enters RUN.
REQ-018 RUN: imem_req=1 when (outstanding + occupancy) < DEPTH; on accept, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
REQ-019 imem_addr shall equal fetch_pc and stay stable while imem_req=1 and imem_gnt=0.
REQ-020 Each accepted response pushes {imem_rdata, pc} to the FIFO tail; pc comes from a per-request address queue (DEPTH entries).
REQ-021 FIFO: out_* shows head entry; push and pop in the same cycle are legal when full or empty-with-bypass is not used (no bypass: minimum latency imem_rvalid -> out_valid is 1 cycle).
REQ-022 Credit rule guarantees no push when full; a response arriving while full is a protocol error and is not stored.
REQ-023 Redirect (any state): same edge clears FIFO, sets fetch_pc=redirect_pc, discards a same-cycle imem_rvalid, sets drop_cnt = in-flight requests excluding that response; imem_req=0 that cycle.
REQ-024 After redirect: if drop_cnt>0 go FLUSH, else stay RUN.
REQ-025 FLUSH: imem_req=0; each imem_rvalid decrements drop_cnt and is discarded; at drop_cnt reaching 0 go RUN next cycle.
REQ-026 out_valid=0 during the redirect cycle's next state until a post-redirect instruction is pushed.
REQ-027 A pop on a redirect cycle is honored by the consumer but has no effect (FIFO cleared).
REQ-028 outstanding counter: +1 on accept, -1 on response, unchanged when both; width clog2(DEPTH)+1.

Reset
REQ-029 Reset low asynchronously: fetch_pc=PC_RESET, state=RUN, FIFO/address queue empty, outstanding=0, drop_cnt=0.
REQ-030 During reset: imem_req=0, out_valid=0, out_instr=0, out_pc=0, out_opcode=0, imem_addr=PC_RESET.
REQ-031 Reset asserted mid-transaction abandons all in-flight requests; first request issues in the first cycle after deassertion.

Structure
REQ-032 Shared package holds PC_RESET default, INSTR_W=32, OPCODE_W=6, fetch state enum.
REQ-033 One sub-module: fetch_fifo (parameterised DEPTH/width synchronous FIFO with full/empty/count), instantiated for the instruction buffer and the address queue.

Verification
REQ-034 Reset release, zero-wait memory (gnt=1, rvalid 1 cycle later), out_ready=1 -> out_pc 0,4,8,... one per cycle, out_opcode = rdata[31:26].
REQ-035 out_ready=0 held -> exactly DEPTH (4) requests issued, then imem_req=0; release -> drains in order, fetching resumes.
REQ-036 gnt held low 3 cycles -> imem_addr stable, no duplicate/skipped pc.
REQ-037 Memory latency 3, redirect to 32'h0000_0100 with 2 in flight -> FLUSH, 2 responses dropped, next out_pc=32'h100.
REQ-038 Redirect coinciding with imem_rvalid and out pop -> response discarded, FIFO empty, drop_cnt correct.
REQ-039 Reset asserted with 3 outstanding -> outputs reset immediately; after release first out_pc=PC_RESET, stale responses never appear.
